// File: rtl/d_latch_pkg.sv
// Shared helpers for the flop-based D latch: lane sizing and parameter legality.
package d_latch_pkg;

    function automatic int unsigned lane_width(input int unsigned width, input int unsigned lanes);
        return (lanes == 0) ? 0 : width / lanes;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned lanes);
        return (width >= 1) && (lanes >= 1) && ((width % lanes) == 0);
    endfunction

endpackage

// File: rtl/d_latch_lane.sv
// One enable lane: hold register with capture-on-enable and a transparent output mux.
module d_latch_lane #(
    parameter int unsigned   W           = 1,
    parameter logic [W-1:0]  RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] held_d;
    logic [W-1:0] held_q;

    always_comb begin
        held_d = held_q;
        if (!rst_n) begin
            held_d = RESET_VALUE;
        end else if (en) begin
            held_d = d;
        end
    end

    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

    // Reset overrides the mux combinationally; enable makes the lane transparent.
    always_comb begin
        q = held_q;
        if (!rst_n) begin
            q = RESET_VALUE;
        end else if (en) begin
            q = d;
        end
    end

endmodule

// File: rtl/d_latch_unit.sv
// Transparent D latch modelled with flops, per-lane enables and complementary outputs.
module d_latch_unit
    import d_latch_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      LANES       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [LANES-1:0] en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b
);

    localparam int unsigned LW = lane_width(WIDTH, LANES);

    if (!params_legal(WIDTH, LANES)) begin : g_bad_params
        $error("d_latch_unit: WIDTH must be >= 1 and divisible by LANES");
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        d_latch_lane #(
            .W           (LW),
            .RESET_VALUE (RESET_VALUE[i*LW +: LW])
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d[i*LW +: LW]),
            .en    (en[i]),
            .q     (q[i*LW +: LW])
        );
    end

    // Taken from the mux output so q and q_b can never agree on any bit.
    assign q_b = ~q;

endmodule

// File: tb/tb_d_latch_unit.sv
// Directed, table-driven checks of d_latch_unit in 1-bit and 8-bit/2-lane configurations.
module tb_d_latch_unit;

    logic       clk;
    logic       rst1_n, en1, d1, q1, qb1;
    logic       rst8_n;
    logic [1:0] en8;
    logic [7:0] d8, q8, qb8;

    int compared;
    int mismatched;

    d_latch_unit #(
        .WIDTH       (1),
        .LANES       (1),
        .RESET_VALUE (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .d     (d1),
        .en    (en1),
        .q     (q1),
        .q_b   (qb1)
    );

    d_latch_unit #(
        .WIDTH       (8),
        .LANES       (2),
        .RESET_VALUE (8'h5A)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .d     (d8),
        .en    (en8),
        .q     (q8),
        .q_b   (qb8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic en;
        logic d;
        logic exp_q;
    } vec1_t;

    typedef struct {
        logic       rst_n;
        logic [1:0] en;
        logic [7:0] d;
        logic [7:0] exp_q;
    } vec8_t;

    vec1_t t1[18];
    vec8_t t8[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst1_n = 1'b0; en1 = 1'b0; d1 = 1'b0;
        rst8_n = 1'b0; en8 = 2'b00; d8 = 8'h00;

        // reset, transparency, hold, alternating en/d, reset with en=1
        t1[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[1]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        t1[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        t1[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        t1[5]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        t1[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        t1[7]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        t1[8]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        t1[9]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        t1[10] = '{1'b1, 1'b0, 1'b0, 1'b1};
        t1[11] = '{1'b1, 1'b1, 1'b0, 1'b0};
        t1[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
        t1[13] = '{1'b1, 1'b1, 1'b1, 1'b1};
        t1[14] = '{1'b1, 1'b0, 1'b0, 1'b1};
        t1[15] = '{1'b1, 1'b1, 1'b1, 1'b1};
        t1[16] = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[17] = '{1'b1, 1'b0, 1'b1, 1'b0};

        // lanes: bits [3:0] are lane 0, [7:4] lane 1; reset value 8'h5A
        t8[0]  = '{1'b0, 2'b11, 8'hFF, 8'h5A};
        t8[1]  = '{1'b1, 2'b00, 8'hFF, 8'h5A};
        t8[2]  = '{1'b1, 2'b11, 8'hA5, 8'hA5};
        t8[3]  = '{1'b1, 2'b00, 8'h00, 8'hA5};
        t8[4]  = '{1'b1, 2'b01, 8'h3C, 8'hAC};
        t8[5]  = '{1'b1, 2'b00, 8'h00, 8'hAC};
        t8[6]  = '{1'b1, 2'b10, 8'h3C, 8'h3C};
        t8[7]  = '{1'b1, 2'b00, 8'hFF, 8'h3C};
        t8[8]  = '{1'b1, 2'b11, 8'hFF, 8'hFF};
        t8[9]  = '{1'b1, 2'b00, 8'h00, 8'hFF};
        t8[10] = '{1'b0, 2'b00, 8'h00, 8'h5A};
        t8[11] = '{1'b1, 2'b00, 8'h00, 8'h5A};
        t8[12] = '{1'b1, 2'b10, 8'h00, 8'h0A};

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            rst1_n = t1[i].rst_n;
            en1    = t1[i].en;
            d1     = t1[i].d;
            #2;
            check($sformatf("w1_q[%0d]", i),  {7'b0, q1},  {7'b0, t1[i].exp_q});
            check($sformatf("w1_qb[%0d]", i), {7'b0, qb1}, {7'b0, ~t1[i].exp_q});
        end

        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            rst8_n = t8[i].rst_n;
            en8    = t8[i].en;
            d8     = t8[i].d;
            #2;
            check($sformatf("w8_q[%0d]", i),  q8,  t8[i].exp_q);
            check($sformatf("w8_qb[%0d]", i), qb8, ~t8[i].exp_q);
        end

        // Within one cycle: held is 8'h0A; transparency and reset act without an edge.
        @(posedge clk);
        #1;
        en8 = 2'b00; d8 = 8'h77;
        #1;
        check("mid_opaque", q8, 8'h0A);
        en8 = 2'b01;
        #1;
        check("mid_en_rise", q8, 8'h07);
        d8 = 8'h71;
        #1;
        check("mid_d_follow", q8, 8'h01);
        rst8_n = 1'b0;
        #1;
        check("mid_reset_q", q8, 8'h5A);
        check("mid_reset_qb", qb8, 8'hA5);
        @(posedge clk);
        #1;
        rst8_n = 1'b1; en8 = 2'b00; d8 = 8'hFF;
        #1;
        check("post_reset_hold", q8, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
